// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter block.
// Redirect-select enum, default width, and the redirect priority encoder.
package pc_pkg;

   localparam int DEFAULT_ADDR_W = 8;

   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_RET,
      SEL_CALL,
      SEL_JUMP,
      SEL_BRANCH,
      SEL_SEQ
   } sel_e;

   // Fixed priority: stall > ret > call > jump > branch > sequential.
   function automatic sel_e pc_sel(input logic stall, input logic ret,
                                   input logic call, input logic jump,
                                   input logic branch);
      if (stall)       return SEL_HOLD;
      else if (ret)    return SEL_RET;
      else if (call)   return SEL_CALL;
      else if (jump)   return SEL_JUMP;
      else if (branch) return SEL_BRANCH;
      else             return SEL_SEQ;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO. A push while full overwrites the
// oldest entry; a pop while empty is ignored and flagged. Falling-edge,
// synchronous active-low reset.
module pc_ras #(
   parameter int ADDR_W    = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top_data,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              unf
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [RAS_DEPTH-1:0][ADDR_W-1:0] mem_q;
   logic [PW-1:0]                    wptr_q;   // next slot to write
   logic [PW-1:0]                    top_idx;
   logic [CW-1:0]                    cnt_q;
   logic                             ovf_q, unf_q;

   // Pointer wraps naturally because depth is a power of two.
   assign top_idx  = wptr_q - PW'(1);
   assign top_data = mem_q[top_idx];
   assign empty    = (cnt_q == '0);
   assign full     = (cnt_q == DEPTH_C);
   assign ovf      = ovf_q;
   assign unf      = unf_q;

   // Storage: contents need no reset, count alone defines validity.
   always_ff @(negedge clk) begin
      if (reset && push) mem_q[wptr_q] <= push_data;
   end

   // Pointer, occupancy count and one-cycle status pulses.
   always_ff @(negedge clk) begin
      if (!reset) begin
         wptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         ovf_q <= push && full;
         unf_q <= pop && empty;
         if (push) begin
            wptr_q <= wptr_q + PW'(1);
            if (!full) cnt_q <= cnt_q + CW'(1);
         end else if (pop && !empty) begin
            wptr_q <= top_idx;
            cnt_q  <= cnt_q - CW'(1);
         end
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter for the fetch path: stall, relative branch, absolute jump
// and call/return through pc_ras. State updates on the falling edge.
// Optional macro PC_WRAP_FLAG_EN adds a sticky wrap_flag output that sets
// when a sequential step or branch carries/borrows past the address width.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W    = DEFAULT_ADDR_W,
   parameter int                STEP      = 1,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int                RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch_en,
   input  logic [ADDR_W-1:0] branch_off,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              call_en,
   input  logic              ret_en,
   output logic [ADDR_W-1:0] read_addr,
   output logic [ADDR_W-1:0] next_addr,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf
`ifdef PC_WRAP_FLAG_EN
   ,
   output logic              wrap_flag
`endif
);

   localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(STEP);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] seq_pc, br_pc, top_data;
   logic              push, pop;
   sel_e              sel;

   assign sel    = pc_sel(stall, ret_en, call_en, jump_en, branch_en);
   assign seq_pc = pc_q + STEP_C;
   // Branch offset is relative to the current PC, not PC+STEP.
   assign br_pc  = pc_q + branch_off;

   // Stack is only touched outside reset; reset clears it anyway.
   assign push = reset && (sel == SEL_CALL);
   assign pop  = reset && (sel == SEL_RET);

   pc_ras #(
      .ADDR_W   (ADDR_W),
      .RAS_DEPTH(RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .push_data(seq_pc),
      .top_data (top_data),
      .empty    (ras_empty),
      .full     (ras_full),
      .ovf      (ras_ovf),
      .unf      (ras_unf)
   );

   // Next-PC mux; reset dominates so next_addr shows RESET_VEC during reset.
   always_comb begin
      pc_d = pc_q;
      if (!reset) begin
         pc_d = RESET_VEC;
      end else begin
         unique case (sel)
            SEL_HOLD:   pc_d = pc_q;
            SEL_RET:    pc_d = ras_empty ? seq_pc : top_data;
            SEL_CALL:   pc_d = jump_addr;
            SEL_JUMP:   pc_d = jump_addr;
            SEL_BRANCH: pc_d = br_pc;
            default:    pc_d = seq_pc;
         endcase
      end
   end

   // PC register.
   always_ff @(negedge clk) begin
      pc_q <= pc_d;
   end

   assign read_addr = pc_q;
   assign next_addr = pc_d;

`ifdef PC_WRAP_FLAG_EN
   logic wrap_hit, wrap_q;

   // Carry on a forward step shows as a smaller result; a borrow on a
   // negative branch shows as a larger one.
   always_comb begin
      wrap_hit = 1'b0;
      if (reset) begin
         if (sel == SEL_SEQ)
            wrap_hit = (seq_pc < pc_q);
         else if (sel == SEL_BRANCH)
            wrap_hit = branch_off[ADDR_W-1] ? (br_pc > pc_q) : (br_pc < pc_q);
      end
   end

   // Sticky wrap indicator, cleared only by reset.
   always_ff @(negedge clk) begin
      if (!reset)        wrap_q <= 1'b0;
      else if (wrap_hit) wrap_q <= 1'b1;
   end

   assign wrap_flag = wrap_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (ADDR_W=8, STEP=1,
// RESET_VEC=8'h10, RAS_DEPTH=4). Inputs change on the rising edge; DUT state
// changes on the falling edge and is sampled 1 time unit later.
module tb_pc_unit;

   logic       clk = 1'b0;
   logic       reset, stall, branch_en, jump_en, call_en, ret_en;
   logic [7:0] branch_off, jump_addr;
   logic [7:0] read_addr, next_addr;
   logic       ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_WRAP_FLAG_EN
   logic       wrap_flag;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_unit #(
      .ADDR_W   (8),
      .STEP     (1),
      .RESET_VEC(8'h10),
      .RAS_DEPTH(4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .branch_en (branch_en),
      .branch_off(branch_off),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .call_en   (call_en),
      .ret_en    (ret_en),
      .read_addr (read_addr),
      .next_addr (next_addr),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
`ifdef PC_WRAP_FLAG_EN
      ,
      .wrap_flag (wrap_flag)
`endif
   );

   typedef struct {
      logic       rst_n, stl, ret, call, jmp, br;
      logic [7:0] boff, jaddr;
      logic [7:0] pc;
      logic       e, f, ovf, unf;
   } vec_t;

   localparam int NV = 39;
   vec_t tbl[NV];

   function automatic vec_t v(input logic rst_n, stl, ret, call, jmp, br,
                              input logic [7:0] boff, jaddr, pc,
                              input logic e, f, ovf, unf);
      vec_t r;
      r.rst_n = rst_n; r.stl = stl; r.ret = ret; r.call = call;
      r.jmp = jmp; r.br = br; r.boff = boff; r.jaddr = jaddr;
      r.pc = pc; r.e = e; r.f = f; r.ovf = ovf; r.unf = unf;
      return r;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      reset = t.rst_n; stall = t.stl; ret_en = t.ret; call_en = t.call;
      jump_en = t.jmp; branch_en = t.br; branch_off = t.boff;
      jump_addr = t.jaddr;
   endtask

   initial begin
      vec_t idle;
      logic exp_wrap;
      reset = 1'b0; stall = 1'b0; ret_en = 1'b0; call_en = 1'b0;
      jump_en = 1'b0; branch_en = 1'b0; branch_off = '0; jump_addr = '0;

      //           rst stl ret cal jmp br  boff   jaddr  pc    e  f  ovf unf
      tbl[0]  = v(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 1, 0, 0, 0);
      tbl[1]  = v(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 1, 0, 0, 0);
      tbl[2]  = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 1, 0, 0, 0);
      tbl[3]  = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h12, 1, 0, 0, 0);
      tbl[4]  = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h13, 1, 0, 0, 0);
      tbl[5]  = v(1, 0, 0, 0, 1, 0, 8'h00, 8'hFE, 8'hFE, 1, 0, 0, 0);
      tbl[6]  = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 0);
      tbl[7]  = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0);
      tbl[8]  = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0);
      tbl[9]  = v(1, 0, 0, 0, 1, 0, 8'h00, 8'h20, 8'h20, 1, 0, 0, 0);
      tbl[10] = v(1, 0, 0, 0, 0, 1, 8'hFC, 8'h00, 8'h1C, 1, 0, 0, 0);
      tbl[11] = v(1, 0, 0, 0, 1, 1, 8'h04, 8'h80, 8'h80, 1, 0, 0, 0);
      tbl[12] = v(1, 0, 0, 0, 1, 0, 8'h00, 8'h05, 8'h05, 1, 0, 0, 0);
      tbl[13] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'h40, 8'h40, 0, 0, 0, 0);
      tbl[14] = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h41, 0, 0, 0, 0);
      tbl[15] = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h42, 0, 0, 0, 0);
      tbl[16] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'h60, 8'h60, 0, 0, 0, 0);
      tbl[17] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h43, 0, 0, 0, 0);
      tbl[18] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h06, 1, 0, 0, 0);
      tbl[19] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h07, 1, 0, 0, 1);
      tbl[20] = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h08, 1, 0, 0, 0);
      // overflow: return addresses 09,32,52,72,92
      tbl[21] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'h31, 8'h31, 0, 0, 0, 0);
      tbl[22] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'h51, 8'h51, 0, 0, 0, 0);
      tbl[23] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'h71, 8'h71, 0, 0, 0, 0);
      tbl[24] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'h91, 8'h91, 0, 1, 0, 0);
      tbl[25] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'hB1, 8'hB1, 0, 1, 1, 0);
      tbl[26] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h92, 0, 0, 0, 0);
      tbl[27] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h72, 0, 0, 0, 0);
      tbl[28] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h52, 0, 0, 0, 0);
      tbl[29] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h32, 1, 0, 0, 0);
      tbl[30] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h33, 1, 0, 0, 1);
      // stall dominance, ret beats call/jump, reset beats ret
      tbl[31] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'hC0, 8'hC0, 0, 0, 0, 0);
      tbl[32] = v(1, 1, 0, 1, 0, 0, 8'h00, 8'h10, 8'hC0, 0, 0, 0, 0);
      tbl[33] = v(1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'hC0, 0, 0, 0, 0);
      tbl[34] = v(1, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h34, 1, 0, 0, 0);
      tbl[35] = v(1, 0, 0, 1, 0, 0, 8'h00, 8'hD0, 8'hD0, 0, 0, 0, 0);
      tbl[36] = v(0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h10, 1, 0, 0, 0);
      tbl[37] = v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 1, 0, 0, 0);
      tbl[38] = v(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h12, 1, 0, 0, 1);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         drive(tbl[i]);
         #1;
         chk("next_addr", i, next_addr, tbl[i].pc);
         @(negedge clk);
         #1;
         chk("read_addr", i, read_addr, tbl[i].pc);
         chk("ras_empty", i, 8'(ras_empty), 8'(tbl[i].e));
         chk("ras_full",  i, 8'(ras_full),  8'(tbl[i].f));
         chk("ras_ovf",   i, 8'(ras_ovf),   8'(tbl[i].ovf));
         chk("ras_unf",   i, 8'(ras_unf),   8'(tbl[i].unf));
`ifdef PC_WRAP_FLAG_EN
         exp_wrap = (i >= 7 && i <= 35);
         chk("wrap_flag", i, 8'(wrap_flag), 8'(exp_wrap));
`endif
      end

      // Multi-cycle stall right after an underflow: PC frozen, the
      // underflow pulse must not linger.
      idle = v(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h12, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         drive(idle);
         @(negedge clk);
         #1;
         chk("stall_pc",  100 + k, read_addr, 8'h12);
         chk("stall_unf", 100 + k, 8'(ras_unf), 8'h00);
      end

      // Release stall: sequential fetch resumes from the held PC.
      @(posedge clk);
      stall = 1'b0;
      @(negedge clk);
      #1;
      chk("resume_pc", 200, read_addr, 8'h13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the SimpleProcessor fetch path. It replaces the fixed 3-bit free-running counter.
- Generates the instruction-memory read address.
- Supports stall, relative branch, absolute jump, and call/return through a small return-address stack (RAS).
- Sits between the control unit (which produces the redirect controls) and instruction memory (which consumes `read_addr`).

Parameters:
- ADDR_W, 8, width of the PC and of every address and offset port.
- STEP, 1, increment per sequential fetch (in address units).
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits).
- RAS_DEPTH, 4, number of return-address stack entries (at least 2, power of 2).

Ports:
- clk, in, 1, clock; all state updates on the falling edge.
- reset, in, 1, reset, synchronous, active-low.
- stall, in, 1, hold the PC and RAS unchanged.
- branch_en, in, 1, take a relative branch.
- branch_off, in, ADDR_W, signed two's-complement offset.
- jump_en, in, 1, take an absolute jump.
- jump_addr, in, ADDR_W, jump target.
- call_en, in, 1, jump to jump_addr and push the return address.
- ret_en, in, 1, pop the return address into the PC.
- read_addr, out, ADDR_W, current PC.
- next_addr, out, ADDR_W, combinational value the PC will take at the next falling edge.
- ras_empty, out, 1, stack holds 0 entries.
- ras_full, out, 1, stack holds RAS_DEPTH entries.
- ras_ovf, out, 1, one-cycle pulse: a push occurred while full.
- ras_unf, out, 1, one-cycle pulse: a pop occurred while empty.

Behaviour:
- Reset (reset==0 sampled at a falling edge):
  - read_addr <= RESET_VEC.
  - RAS count <= 0.
  - ras_ovf, ras_unf <= 0.
  - Reset overrides every other input, including mid-call or mid-stall.
- Priority when not in reset: stall > ret_en > call_en > jump_en > branch_en > sequential.
  - stall: PC, RAS contents and count all unchanged; ras_ovf and ras_unf are 0.
  - ret_en, RAS not empty: PC <= top of stack; count decrements.
  - ret_en, RAS empty: PC <= PC+STEP; ras_unf pulses for one cycle.
  - call_en: PC <= jump_addr; push PC+STEP.
    - If the RAS is full, the oldest entry is overwritten (circular buffer), count stays RAS_DEPTH, and ras_ovf pulses for one cycle.
  - jump_en: PC <= jump_addr.
  - branch_en: PC <= PC + branch_off. The offset is relative to the current PC, not PC+STEP.
  - Otherwise: PC <= PC + STEP.
- Arithmetic: all additions are modulo 2^ADDR_W. Wrap from the top address to 0 is silent and legal.
- Multiple redirect inputs asserted together: the lower-priority inputs are ignored with no side effects. For example, with call_en and ret_en both high, only the pop occurs.
- Latency:
  - The redirect target appears on read_addr after the falling edge at which the redirect is sampled.
  - next_addr always equals the value read_addr will take at that edge. During reset==0, next_addr = RESET_VEC.
- RAS status flags:
  - ras_empty and ras_full are registered views of the count.
  - Both are valid in the cycle after reset: empty=1, full=0.

Optional Feature:
- Macro: PC_WRAP_FLAG_EN.
- When defined:
  - Adds output port wrap_flag (1 bit).
  - wrap_flag is sticky; it sets when a sequential increment or branch carries or borrows past the ADDR_W boundary.
  - It clears only on reset.
- When undefined:
  - The port is absent.
  - No carry logic is generated; behaviour is otherwise identical.

Decomposition:
- Shared package pc_pkg holds:
  - typedef of the redirect-select enum (SEL_HOLD, SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_SEQ);
  - the constant DEFAULT_ADDR_W = 8.
- One sub-module, pc_ras: a circular LIFO.
  - Parameters: ADDR_W, RAS_DEPTH.
  - Ports: push, pop, push_data, top_data, empty, full, ovf, unf.
- pc_unit contains the next-PC mux, the priority encoder and the PC register.

Test Plan:
- Reset and sequential fetch (ADDR_W=8, STEP=1, RESET_VEC=8'h10): hold reset low for 2 edges, then release → read_addr = 10,11,12,13 on successive falling edges.
- Wrap: start at PC=8'hFE and run sequential → FE, FF, 00, 01. With PC_WRAP_FLAG_EN, wrap_flag rises at the 00 edge and stays high.
- Branch: at PC=8'h20 apply branch_off=8'hFC (-4) → PC=1C. Then a jump to 8'h80 with branch_en also high → PC=80; the branch is ignored.
- Call/return nesting:
  - call to 40 at PC=05, then call to 60 at PC=42.
  - ret → PC=43; ret → PC=06; a third ret → PC=07 with a one-cycle ras_unf pulse.
- RAS overflow (RAS_DEPTH=4): perform 5 calls from return addresses A1..A5 → ras_ovf pulses on the 5th call. Five rets then return A5, A4, A3, A2, then a ras_unf pulse (A1 was overwritten).
- Stall and mid-operation reset:
  - stall high with call_en high → PC and count unchanged.
  - reset low in the same cycle as ret_en with a non-empty RAS → PC=RESET_VEC and ras_empty=1 next cycle.
